// File: rtl/branch_table_sequencer.sv
// Sequences all accesses to a single-port 2-bit-counter pattern history table:
// reset clear sweep, Decode lookups and MEM-stage saturating write-backs for the one in-flight branch.
module branch_table_sequencer #(
   parameter int         IDX_W    = 8,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lookup_req,
   input  logic [IDX_W-1:0] lookup_idx,
   output logic             lookup_grant,
   output logic             pred_valid,
   output logic             pred_taken,
   input  logic             resolve_valid,
   input  logic             resolve_taken,
   output logic             mispredict,
   output logic             tbl_en,
   output logic             tbl_we,
   output logic [IDX_W-1:0] tbl_addr,
   output logic [1:0]       tbl_wdata,
   input  logic [1:0]       tbl_rdata,
   output logic             ready,
   output logic             err_spurious,
   output logic [31:0]      total_branches,
   output logic [31:0]      correct_predictions,
   output logic [2:0]       o_dbg_state
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_LOOKUP = 3'd2,
      S_WAIT   = 3'd3,
      S_UPDATE = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [IDX_W-1:0] r_sweep_addr;
   logic [IDX_W-1:0] r_idx;
   logic [1:0]       r_ctr;
   logic             r_pred;
   logic             r_outcome;
   logic             r_ready;
   logic             r_err;
   logic [31:0]      r_total;
   logic [31:0]      r_correct;
   logic [1:0]       w_sat_ctr;

   // The counter latched at lookup is written back directly, so no second read is needed.
   always_comb begin
      w_sat_ctr = r_ctr;
      if (r_outcome) begin
         if (r_ctr != 2'b11) w_sat_ctr = r_ctr + 2'd1;
      end else begin
         if (r_ctr != 2'b00) w_sat_ctr = r_ctr - 2'd1;
      end
   end

   always_comb begin
      w_next_state = r_state;
      lookup_grant = 1'b0;
      pred_valid   = 1'b0;
      pred_taken   = 1'b0;
      mispredict   = 1'b0;
      tbl_en       = 1'b0;
      tbl_we       = 1'b0;
      tbl_addr     = '0;
      tbl_wdata    = 2'b00;
      case (r_state)
         S_INIT: begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = r_sweep_addr;
            tbl_wdata = INIT_CTR;
            if (r_sweep_addr == {IDX_W{1'b1}}) w_next_state = S_IDLE;
         end
         S_IDLE: begin
            lookup_grant = lookup_req;
            if (lookup_req) begin
               tbl_en       = 1'b1;
               tbl_addr     = lookup_idx;
               w_next_state = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            pred_valid   = 1'b1;
            pred_taken   = tbl_rdata[1];
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (resolve_valid) w_next_state = S_UPDATE;
         end
         S_UPDATE: begin
            tbl_en       = 1'b1;
            tbl_we       = 1'b1;
            tbl_addr     = r_idx;
            tbl_wdata    = w_sat_ctr;
            mispredict   = (r_pred != r_outcome);
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_INIT;
         r_sweep_addr <= '0;
         r_idx        <= '0;
         r_ctr        <= 2'b00;
         r_pred       <= 1'b0;
         r_outcome    <= 1'b0;
         r_ready      <= 1'b0;
         r_err        <= 1'b0;
         r_total      <= 32'd0;
         r_correct    <= 32'd0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_INIT) begin
            r_sweep_addr <= r_sweep_addr + 1'b1;
            if (w_next_state == S_IDLE) r_ready <= 1'b1;
         end
         if (lookup_grant) r_idx <= lookup_idx;
         if (r_state == S_LOOKUP) begin
            r_ctr  <= tbl_rdata;
            r_pred <= tbl_rdata[1];
         end
         if (r_state == S_WAIT && resolve_valid) r_outcome <= resolve_taken;
         // Any resolve outside WAIT has no branch to attach to.
         if (r_state != S_WAIT && resolve_valid) r_err <= 1'b1;
         if (r_state == S_UPDATE) begin
            r_total <= r_total + 32'd1;
            if (!mispredict) r_correct <= r_correct + 32'd1;
         end
      end
   end

   assign ready               = r_ready;
   assign err_spurious        = r_err;
   assign total_branches      = r_total;
   assign correct_predictions = r_correct;
   assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_branch_table_sequencer.sv
// Bench for branch_table_sequencer with IDX_W=4: behavioural PHT RAM plus an arithmetic reference model.
module tb_branch_table_sequencer;
   localparam int IDX_W = 4;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             lookup_req;
   logic [IDX_W-1:0] lookup_idx;
   logic             lookup_grant;
   logic             pred_valid;
   logic             pred_taken;
   logic             resolve_valid;
   logic             resolve_taken;
   logic             mispredict;
   logic             tbl_en;
   logic             tbl_we;
   logic [IDX_W-1:0] tbl_addr;
   logic [1:0]       tbl_wdata;
   logic [1:0]       tbl_rdata;
   logic             ready;
   logic             err_spurious;
   logic [31:0]      total_branches;
   logic [31:0]      correct_predictions;
   logic [2:0]       dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt   = 0;

   // Reference model state
   int ref_pht [DEPTH];
   int ref_total;
   int ref_correct;
   bit ref_err;

   // PHT RAM: single port, synchronous read
   logic [1:0] mem [DEPTH];

   branch_table_sequencer #(.IDX_W(IDX_W), .INIT_CTR(2'b01)) dut (
      .clk(clk), .rst(rst),
      .lookup_req(lookup_req), .lookup_idx(lookup_idx), .lookup_grant(lookup_grant),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .mispredict(mispredict),
      .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
      .tbl_rdata(tbl_rdata), .ready(ready), .err_spurious(err_spurious),
      .total_branches(total_branches), .correct_predictions(correct_predictions),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tbl_en) begin
         if (tbl_we) mem[tbl_addr] <= tbl_wdata;
         else        tbl_rdata     <= mem[tbl_addr];
      end
      if (tbl_en === 1'b1 && tbl_we === 1'b1) wr_cnt <= wr_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic ref_clear;
      for (int i = 0; i < DEPTH; i++) ref_pht[i] = 1;
      ref_total = 0;
      ref_correct = 0;
      ref_err = 1'b0;
   endtask

   // Runs the 16-cycle sweep from the first INIT cycle, with lookup_req held high throughout.
   task automatic check_sweep(input string tag);
      int bad = 0;
      lookup_req = 1'b1;
      lookup_idx = IDX_W'($urandom_range(0, DEPTH-1));
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         n_checks++;
         if (tbl_en !== 1'b1 || tbl_we !== 1'b1 || tbl_addr !== IDX_W'(i) || tbl_wdata !== 2'b01 ||
             lookup_grant !== 1'b0 || ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_sweep[%0d]: en=%b we=%b addr=%0d wdata=%b grant=%b ready=%b, required en=1 we=1 addr=%0d wdata=01 grant=0 ready=0",
                     tag, i, tbl_en, tbl_we, tbl_addr, tbl_wdata, lookup_grant, ready, i);
         end
         step;
      end
      #1;
      n_checks++;
      if (ready !== 1'b1 || lookup_grant !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_ready: ready=%b grant=%b, required 1 1", tag, ready, lookup_grant);
      end
      lookup_req = 1'b0;
      #1;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== 2'b01) bad++;
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL %s_table_init: %0d entries not 01, required 0", tag, bad);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step;
      rst = 1'b0;
      #1;
      n_checks++;
      if (ready !== 1'b0 || total_branches !== 32'd0 || correct_predictions !== 32'd0 ||
          err_spurious !== 1'b0 || pred_valid !== 1'b0 || mispredict !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: ready=%b total=%0d correct=%0d err=%b pv=%b mis=%b, required all 0",
                  ready, total_branches, correct_predictions, err_spurious, pred_valid, mispredict);
      end
      ref_clear();
      check_sweep("reset");
   endtask

   // One branch through lookup, optional WAIT cycles, resolve and update, checked against the model.
   task automatic do_branch(input int idx, input bit taken, input int waits, input bit hold, input bit spur);
      int         c = ref_pht[idx];
      bit         exp_pred = (c >= 2);
      logic [1:0] exp_new;
      bit         exp_mis = (exp_pred != taken);
      int         w0;
      exp_new = taken ? 2'((c + 1 > 3) ? 3 : c + 1) : 2'((c - 1 < 0) ? 0 : c - 1);

      lookup_req = 1'b1;
      lookup_idx = IDX_W'(idx);
      #1;
      n_checks++;
      if (lookup_grant !== 1'b1 || tbl_en !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== IDX_W'(idx)) begin
         n_errors++;
         $display("FAIL grant idx=%0d: grant=%b en=%b we=%b addr=%0d, required 1 1 0 %0d",
                  idx, lookup_grant, tbl_en, tbl_we, tbl_addr, idx);
      end
      step;
      lookup_req = hold;
      lookup_idx = IDX_W'(idx ^ 3);
      resolve_valid = spur;
      resolve_taken = ~taken;
      if (spur) ref_err = 1'b1;
      #1;
      n_checks++;
      if (pred_valid !== 1'b1 || pred_taken !== exp_pred || lookup_grant !== 1'b0 || tbl_en !== 1'b0) begin
         n_errors++;
         $display("FAIL predict idx=%0d: pv=%b taken=%b grant=%b en=%b, required 1 %b 0 0",
                  idx, pred_valid, pred_taken, lookup_grant, tbl_en, exp_pred);
      end
      step;
      resolve_valid = 1'b0;
      for (int k = 0; k < waits; k++) begin
         #1;
         n_checks++;
         if (lookup_grant !== 1'b0 || tbl_en !== 1'b0 || pred_valid !== 1'b0 || mispredict !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_stall idx=%0d cyc=%0d: grant=%b en=%b pv=%b mis=%b, required all 0",
                     idx, k, lookup_grant, tbl_en, pred_valid, mispredict);
         end
         step;
      end
      w0 = wr_cnt;
      resolve_valid = 1'b1;
      resolve_taken = taken;
      step;
      resolve_valid = 1'b0;
      #1;
      n_checks++;
      if (tbl_en !== 1'b1 || tbl_we !== 1'b1 || tbl_addr !== IDX_W'(idx) || tbl_wdata !== exp_new ||
          mispredict !== exp_mis || lookup_grant !== 1'b0 || wr_cnt != w0) begin
         n_errors++;
         $display("FAIL update idx=%0d: en=%b we=%b addr=%0d wdata=%b mis=%b grant=%b extra_writes=%0d, required 1 1 %0d %b %b 0 0",
                  idx, tbl_en, tbl_we, tbl_addr, tbl_wdata, mispredict, lookup_grant, wr_cnt - w0,
                  idx, exp_new, exp_mis);
      end
      ref_pht[idx] = int'(exp_new);
      ref_total++;
      if (!exp_mis) ref_correct++;
      step;
      #1;
      n_checks++;
      if (total_branches !== 32'(ref_total) || correct_predictions !== 32'(ref_correct) ||
          mispredict !== 1'b0 || err_spurious !== ref_err || mem[idx] !== exp_new) begin
         n_errors++;
         $display("FAIL stats idx=%0d: total=%0d correct=%0d mis=%b err=%b mem=%b, required %0d %0d 0 %b %b",
                  idx, total_branches, correct_predictions, mispredict, err_spurious, mem[idx],
                  ref_total, ref_correct, ref_err, exp_new);
      end
      if (hold) begin
         n_checks++;
         if (lookup_grant !== 1'b1) begin
            n_errors++;
            $display("FAIL held_grant idx=%0d: grant=%b, required 1", idx, lookup_grant);
         end
         lookup_req = 1'b0;
         #1;
      end
   endtask

   task automatic test_saturate_taken;
      for (int r = 0; r < 4; r++) do_branch(5, 1'b1, r, 1'b0, 1'b0);
      n_checks++;
      if (total_branches !== 32'd4 || correct_predictions !== 32'd3 || mem[5] !== 2'b11) begin
         n_errors++;
         $display("FAIL taken_saturation: total=%0d correct=%0d mem5=%b, required 4 3 11",
                  total_branches, correct_predictions, mem[5]);
      end
   endtask

   task automatic test_saturate_not_taken;
      for (int r = 0; r < 3; r++) do_branch(9, 1'b0, 1, 1'b0, 1'b0);
      n_checks++;
      if (mem[9] !== 2'b00 || total_branches !== 32'd7 || correct_predictions !== 32'd6) begin
         n_errors++;
         $display("FAIL not_taken_saturation: mem9=%b total=%0d correct=%0d, required 00 7 6",
                  mem[9], total_branches, correct_predictions);
      end
   endtask

   task automatic test_wait_stall;
      do_branch(7, 1'b1, 10, 1'b1, 1'b0);
   endtask

   task automatic test_spurious_idle;
      int w0 = wr_cnt;
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      #1;
      n_checks++;
      if (tbl_en !== 1'b0 || mispredict !== 1'b0) begin
         n_errors++;
         $display("FAIL spurious_no_access: en=%b mis=%b, required 0 0", tbl_en, mispredict);
      end
      step;
      resolve_valid = 1'b0;
      ref_err = 1'b1;
      #1;
      n_checks++;
      if (err_spurious !== 1'b1 || wr_cnt != w0 || total_branches !== 32'(ref_total) ||
          correct_predictions !== 32'(ref_correct) || lookup_grant !== 1'b0) begin
         n_errors++;
         $display("FAIL spurious_idle: err=%b writes=%0d total=%0d correct=%0d, required 1 0 %0d %0d",
                  err_spurious, wr_cnt - w0, total_branches, correct_predictions, ref_total, ref_correct);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         do_branch($urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 4) == 0) test_spurious_idle();
      end
   endtask

   task automatic test_reset_in_wait;
      lookup_req = 1'b1;
      lookup_idx = 4'd3;
      step;
      lookup_req = 1'b0;
      step;
      rst = 1'b1;
      resolve_valid = 1'b1;
      resolve_taken = 1'b1;
      #1;
      n_checks++;
      if (tbl_we !== 1'b0 || mispredict !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_wait_same_cycle: we=%b mis=%b, required 0 0", tbl_we, mispredict);
      end
      step;
      rst = 1'b0;
      resolve_valid = 1'b0;
      #1;
      n_checks++;
      if (total_branches !== 32'd0 || correct_predictions !== 32'd0 || err_spurious !== 1'b0 ||
          ready !== 1'b0 || mispredict !== 1'b0 || pred_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_wait_cleared: total=%0d correct=%0d err=%b ready=%b mis=%b pv=%b, required all 0",
                  total_branches, correct_predictions, err_spurious, ready, mispredict, pred_valid);
      end
      ref_clear();
      check_sweep("rewait");
      do_branch(3, 1'b1, 2, 1'b0, 1'b0);
   endtask

   initial begin
      rst           = 1'b1;
      lookup_req    = 1'b0;
      lookup_idx    = '0;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
      ref_clear();
      test_reset();
      test_saturate_taken();
      test_saturate_not_taken();
      test_wait_stall();
      test_spurious_idle();
      test_random();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/branch_table_sequencer.md
Name: branch_table_sequencer

Overview:
- Owns the single-port, synchronous-read 2-bit-counter pattern history table (PHT) used for branch prediction.
- Sequences every access to that RAM: the reset-time clear sweep, Decode-stage prediction lookups, and MEM-stage saturating-counter write-backs.
- Tracks the one in-flight branch, which is legal because branches never issue back-to-back.
- Sits between the Decode/MEM pipeline control and the PHT RAM. Produces prediction, mispredict and accuracy statistics.

Parameters:
IDX_W, 8, PHT index width; table depth is 2^IDX_W entries
INIT_CTR, 2'b01, counter value written to every entry during the clear sweep (weakly not-taken)

Ports:
clk  in  1  system clock, all state changes on posedge
rst  in  1  synchronous reset, active-high
lookup_req  in  1  Decode requests a prediction; held until granted
lookup_idx  in  IDX_W  PHT index of the requesting branch (PC[IDX_W+1:2])
lookup_grant  out  1  lookup accepted this cycle (combinational)
pred_valid  out  1  one-cycle pulse: pred_taken is valid
pred_taken  out  1  predicted direction (counter MSB)
resolve_valid  in  1  MEM stage resolves the outstanding branch
resolve_taken  in  1  actual branch outcome
mispredict  out  1  one-cycle pulse: resolved outcome differs from prediction
tbl_en  out  1  PHT RAM enable
tbl_we  out  1  PHT RAM write enable
tbl_addr  out  IDX_W  PHT RAM address
tbl_wdata  out  2  PHT RAM write data
tbl_rdata  in  2  PHT RAM read data, valid the cycle after a read enable
ready  out  1  clear sweep complete
err_spurious  out  1  sticky flag: resolve_valid seen while no branch outstanding
total_branches  out  32  resolved-branch count
correct_predictions  out  32  correctly predicted count

Behaviour:
- Reset:
  - rst=1 at a posedge from any state: state=INIT, sweep address=0, all outputs 0, both stat counters and err_spurious cleared.
  - A pending lookup or update is discarded. No mispredict is emitted.
- FSM states: INIT, IDLE, LOOKUP, WAIT, UPDATE.
- INIT:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=sweep address, tbl_wdata=INIT_CTR, then the address increments.
  - After writing address 2^IDX_W-1, go to IDLE and set ready=1. ready stays 1 until the next rst.
  - The sweep takes exactly 2^IDX_W cycles. lookup_grant=0 throughout.
- IDLE:
  - lookup_grant = lookup_req. On grant: tbl_en=1, tbl_we=0, tbl_addr=lookup_idx, lookup_idx is latched, go to LOOKUP.
  - With no request the RAM is idle (tbl_en=0).
- LOOKUP:
  - tbl_rdata is valid. pred_valid=1, pred_taken=tbl_rdata[1].
  - The full 2-bit counter and the prediction are latched. Go to WAIT.
- WAIT:
  - lookup_grant=0, so a new requester stalls.
  - On resolve_valid, latch resolve_taken and go to UPDATE.
- UPDATE:
  - tbl_en=1, tbl_we=1, tbl_addr=latched idx.
  - tbl_wdata=saturating counter: taken -> min(ctr+1,3); not-taken -> max(ctr-1,0). 2'b11 stays 2'b11 on taken; 2'b00 stays 2'b00 on not-taken.
  - mispredict=(latched prediction != latched outcome).
  - total_branches+1; correct_predictions+1 if no mispredict. Then go to IDLE.
- Latency:
  - Grant to pred_valid: 1 cycle.
  - resolve_valid to mispredict/write: 1 cycle.
  - UPDATE to next possible grant: 1 cycle (IDLE).
- Because the latched counter is written back, the update needs no second RAM read. This is valid because only one branch is outstanding.
- resolve_valid in INIT, IDLE, LOOKUP or UPDATE is ignored (no state change, no table write) and sets err_spurious.
- lookup_req in LOOKUP, WAIT, UPDATE or INIT is not granted; the requester holds request and index.
- Stat counters wrap modulo 2^32 with no saturation.
- Only one RAM operation is issued per cycle; tbl_we=1 implies tbl_en=1.

Test Plan:
- IDX_W=4: assert rst for 1 cycle -> exactly 16 consecutive writes of 2'b01 to addresses 0..15, ready rises on cycle 17; lookup_req held high during INIT is never granted.
- After init, lookup idx=5 -> grant same cycle, pred_valid next cycle with pred_taken=0; resolve taken -> next cycle tbl_we=1, addr=5, wdata=2'b10, mispredict=1, total=1, correct=0.
- Repeat idx=5 taken three more times -> written values 2'b11, 2'b11, 2'b11 (saturation), predictions 1,1,1, correct_predictions=3, total=4.
- Preload idx=9 to 2'b00 via resolve not-taken loop -> further not-taken writes stay 2'b00, mispredict=0.
- In WAIT, hold lookup_req for 10 cycles -> no grant until the cycle after UPDATE; resolve_valid pulsed while IDLE -> err_spurious=1, no table write, counters unchanged.
- Assert rst during WAIT with resolve_valid=1 in the same cycle -> no UPDATE write, no mispredict, counters=0, sweep restarts at address 0.
